// File: rtl/hdcpu_beat_sequencer.sv
// Beat and run-state sequencer for the hardwired HD-CPU controller.
// Issues the one-hot machine-cycle beat W[3:1], tracks ST0, latches MODE and counts cycles.
module hdcpu_beat_sequencer #(
    parameter int CNT_W = 8
) (
    input  logic             T3,
    input  logic             CLR,
    input  logic             QD,
    input  logic [2:0]       SW,
    input  logic             SHORT,
    input  logic             LONG,
    input  logic             STOP,
    input  logic             SST0,
    output logic [2:0]       W,
    output logic             ST0,
    output logic             RUN,
    output logic [2:0]       MODE,
    output logic [CNT_W-1:0] CYCLES
);

    typedef enum logic [1:0] {
        HALT = 2'd0,
        B1   = 2'd1,
        B2   = 2'd2,
        B3   = 2'd3
    } state_t;

    localparam logic [CNT_W-1:0] CNT_ONE = 1;

    state_t state_q, state_d;
    state_t resume_q, resume_d;
    state_t nat_beat;
    logic   cycle_end;
    logic   mode_load;

    function automatic logic [2:0] beat_onehot(input state_t s);
        case (s)
            B1:      beat_onehot = 3'b001;
            B2:      beat_onehot = 3'b010;
            B3:      beat_onehot = 3'b100;
            default: beat_onehot = 3'b000;
        endcase
    endfunction

    // NOTE: every signal driven here gets a default first, so no path can infer a latch.
    always_comb begin
        nat_beat  = B1;
        state_d   = state_q;
        resume_d  = resume_q;
        cycle_end = 1'b0;
        mode_load = 1'b0;

        case (state_q)
            B1:      nat_beat = SHORT ? B1 : B2;
            B2:      nat_beat = LONG  ? B3 : B1;
            default: nat_beat = B1;
        endcase

        if (state_q == HALT) begin
            if (QD) begin
                state_d   = resume_q;
                mode_load = 1'b1;
            end
        end else begin
            // A cycle end still counts when STOP halts on the same edge.
            cycle_end = (nat_beat == B1);
            if (STOP) begin
                state_d  = HALT;
                resume_d = nat_beat;
            end else begin
                state_d  = nat_beat;
            end
        end
    end

    // NOTE: state registers use non-blocking assignments so all flops sample the same pre-edge values.
    always_ff @(posedge T3 or negedge CLR) begin
        if (!CLR) begin
            state_q  <= HALT;
            resume_q <= B1;
            W        <= 3'b000;
            RUN      <= 1'b0;
            ST0      <= 1'b0;
            MODE     <= 3'b000;
            CYCLES   <= '0;
        end else begin
            state_q  <= state_d;
            resume_q <= resume_d;
            W        <= beat_onehot(state_d);
            RUN      <= (state_d != HALT);
            if (mode_load) begin
                MODE <= SW;
            end
            if (cycle_end) begin
                CYCLES <= CYCLES + CNT_ONE;
                if (SST0) begin
                    ST0 <= 1'b1;
                end
            end
        end
    end

endmodule

// File: tb/tb_hdcpu_beat_sequencer.sv
// Self-checking bench for hdcpu_beat_sequencer: directed scenarios followed by
// randomized stimulus, all compared against a beat-number reference model.
module tb_hdcpu_beat_sequencer;

    localparam int CNT_W = 8;

    logic             T3;
    logic             CLR;
    logic             QD;
    logic [2:0]       SW;
    logic             SHORT;
    logic             LONG;
    logic             STOP;
    logic             SST0;
    logic [2:0]       W;
    logic             ST0;
    logic             RUN;
    logic [2:0]       MODE;
    logic [CNT_W-1:0] CYCLES;

    int total = 0;
    int bad   = 0;

    // Reference model: beat number 0 = halted, 1..3 = W1..W3.
    int m_beat;
    int m_resume;
    int m_st0;
    int m_mode;
    int m_cyc;

    hdcpu_beat_sequencer #(.CNT_W(CNT_W)) dut (
        .T3     (T3),
        .CLR    (CLR),
        .QD     (QD),
        .SW     (SW),
        .SHORT  (SHORT),
        .LONG   (LONG),
        .STOP   (STOP),
        .SST0   (SST0),
        .W      (W),
        .ST0    (ST0),
        .RUN    (RUN),
        .MODE   (MODE),
        .CYCLES (CYCLES)
    );

    initial begin
        T3 = 1'b0;
        forever #5 T3 = ~T3;
    end

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s: got=%0h expected=%0h at %0t", tag, got, exp, $time);
        end
    endtask

    function automatic int model_w();
        return (m_beat == 0) ? 0 : (1 << (m_beat - 1));
    endfunction

    task automatic model_reset();
        m_beat   = 0;
        m_resume = 1;
        m_st0    = 0;
        m_mode   = 0;
        m_cyc    = 0;
    endtask

    task automatic model_edge(input logic qd, input int sw, input logic sh, input logic lg,
                              input logic sp, input logic ss);
        int n;
        if (m_beat == 0) begin
            if (qd) begin
                m_beat = m_resume;
                m_mode = sw;
            end
        end else begin
            if (m_beat == 1)      n = sh ? 1 : 2;
            else if (m_beat == 2) n = lg ? 3 : 1;
            else                  n = 1;
            if (n == 1) begin
                m_cyc = (m_cyc + 1) % (1 << CNT_W);
                if (ss) m_st0 = 1;
            end
            if (sp) begin
                m_resume = n;
                m_beat   = 0;
            end else begin
                m_beat = n;
            end
        end
    endtask

    task automatic check_all(input string tag);
        check({tag, ".W"},      {29'd0, W},                   m_beat == 0 ? 32'd0 : 32'(model_w()));
        check({tag, ".RUN"},    {31'd0, RUN},                 32'(m_beat != 0));
        check({tag, ".ST0"},    {31'd0, ST0},                 32'(m_st0));
        check({tag, ".MODE"},   {29'd0, MODE},                32'(m_mode));
        check({tag, ".CYCLES"}, {{(32-CNT_W){1'b0}}, CYCLES}, 32'(m_cyc));
    endtask

    task automatic step(input string tag, input logic qd, input logic [2:0] sw, input logic sh,
                        input logic lg, input logic sp, input logic ss);
        @(negedge T3);
        QD = qd; SW = sw; SHORT = sh; LONG = lg; STOP = sp; SST0 = ss;
        model_edge(qd, int'(sw), sh, lg, sp, ss);
        @(posedge T3);
        #1;
        check_all(tag);
    endtask

    task automatic check_zero(input string tag);
        check({tag, ".W"},      {29'd0, W},                   32'd0);
        check({tag, ".RUN"},    {31'd0, RUN},                 32'd0);
        check({tag, ".ST0"},    {31'd0, ST0},                 32'd0);
        check({tag, ".MODE"},   {29'd0, MODE},                32'd0);
        check({tag, ".CYCLES"}, {{(32-CNT_W){1'b0}}, CYCLES}, 32'd0);
    endtask

    // Drops CLR between edges and checks the outputs clear before the next T3 rise.
    task automatic async_reset(input string tag);
        @(negedge T3);
        QD = 1'b0; SHORT = 1'b0; LONG = 1'b0; STOP = 1'b0; SST0 = 1'b0;
        #2 CLR = 1'b0;
        #1;
        check_zero({tag, ".async"});
        model_reset();
        @(posedge T3);
        #1;
        check_zero({tag, ".held"});
        @(negedge T3);
        CLR = 1'b1;
    endtask

    initial begin
        CLR = 1'b0; QD = 1'b0; SW = 3'b000;
        SHORT = 1'b0; LONG = 1'b0; STOP = 1'b0; SST0 = 1'b0;
        model_reset();

        // Reset held across clock edges, then idle without QD.
        @(posedge T3);
        @(posedge T3);
        #1;
        check_zero("reset");
        @(negedge T3);
        CLR = 1'b1;
        for (int i = 0; i < 5; i++) step("idle", 1'b0, 3'b000, 1'b1, 1'b1, 1'b1, 1'b1);

        // Start and default W1/W2 alternation.
        step("start", 1'b1, 3'b101, 1'b0, 1'b0, 1'b0, 1'b0);
        check("start.mode", {29'd0, MODE}, 32'h5);
        check("start.w1",   {29'd0, W},    32'h1);
        for (int i = 0; i < 5; i++) step("dflt", 1'b0, 3'b101, 1'b0, 1'b0, 1'b0, 1'b0);
        check("dflt.w2", {29'd0, W}, 32'h2);

        // LONG in W2, then SHORT beating LONG in W1.
        step("long", 1'b0, 3'b101, 1'b0, 1'b1, 1'b0, 1'b0);
        check("long.w3", {29'd0, W}, 32'h4);
        step("after_w3", 1'b0, 3'b101, 1'b0, 1'b0, 1'b0, 1'b0);
        check("after_w3.w1", {29'd0, W}, 32'h1);
        step("short", 1'b0, 3'b101, 1'b1, 1'b1, 1'b0, 1'b0);
        check("short.w1", {29'd0, W}, 32'h1);

        // STOP in W2 with LONG, resume into W3 with a new mode.
        step("to_w2", 1'b0, 3'b101, 1'b0, 1'b0, 1'b0, 1'b0);
        step("stop", 1'b0, 3'b101, 1'b0, 1'b1, 1'b1, 1'b0);
        check("stop.w",   {29'd0, W},   32'h0);
        check("stop.run", {31'd0, RUN}, 32'h0);
        step("resume", 1'b1, 3'b010, 1'b0, 1'b0, 1'b0, 1'b0);
        check("resume.w",    {29'd0, W},    32'h4);
        check("resume.mode", {29'd0, MODE}, 32'h2);
        step("qd_run", 1'b1, 3'b111, 1'b0, 1'b0, 1'b0, 1'b0);
        check("qd_run.mode", {29'd0, MODE}, 32'h2);

        // SST0 only takes effect on a cycle-end edge.
        step("sst0_w1", 1'b0, 3'b111, 1'b0, 1'b0, 1'b0, 1'b1);
        check("sst0_w1.st0", {31'd0, ST0}, 32'h0);
        step("sst0_w2", 1'b0, 3'b111, 1'b0, 1'b0, 1'b0, 1'b1);
        check("sst0_w2.st0", {31'd0, ST0}, 32'h1);
        for (int i = 0; i < 4; i++) step("st0_hold", 1'b0, 3'b000, 1'b0, 1'b0, 1'b0, 1'b0);
        check("st0_hold.st0", {31'd0, ST0}, 32'h1);

        // Async reset in the middle of W3.
        step("to_w2b", 1'b0, 3'b000, 1'b0, 1'b0, 1'b0, 1'b0);
        step("to_w3", 1'b0, 3'b000, 1'b0, 1'b1, 1'b0, 1'b0);
        check("to_w3.w", {29'd0, W}, 32'h4);
        async_reset("mid_w3");
        for (int i = 0; i < 3; i++) step("post_rst", 1'b0, 3'b000, 1'b0, 1'b0, 1'b0, 1'b0);

        // Counter wrap: 2^CNT_W default cycles of two beats each.
        step("wrap_start", 1'b1, 3'b001, 1'b0, 1'b0, 1'b0, 1'b0);
        for (int i = 0; i < 2 * (1 << CNT_W); i++)
            step("wrap", 1'b0, 3'b001, 1'b0, 1'b0, 1'b0, 1'b0);
        check("wrap.cycles", {{(32-CNT_W){1'b0}}, CYCLES}, 32'h0);
        check("wrap.w",      {29'd0, W},                   32'h1);

        // Randomized traffic against the model.
        for (int i = 0; i < 600; i++) begin
            if ($urandom_range(0, 79) == 0) begin
                async_reset("rnd");
            end else begin
                step("rnd",
                     $urandom_range(0, 5) == 0,
                     3'($urandom_range(0, 7)),
                     $urandom_range(0, 3) == 0,
                     $urandom_range(0, 2) == 0,
                     $urandom_range(0, 9) == 0,
                     $urandom_range(0, 15) == 0);
            end
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
